// File: rtl/fp16_add_stream.sv
//------------------------------------------------------------------------------
// Module      : fp16_add_stream
// Description : Valid/ready front-end for a fixed-latency fp16 adder with
//               credit-based admission and an in-order result FIFO.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fp16_add_stream #(
    parameter int ADD_LAT    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic [15:0]      add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_inf_w = $clog2(ADD_LAT + 2);
    localparam int c_sum_w = $clog2(FIFO_DEPTH + ADD_LAT + 2);

    logic [ADD_LAT:0]   r_vld_pipe;
    logic [TAG_W-1:0]   r_tag_pipe [ADD_LAT+1];
    logic [15:0]        r_add_a;
    logic [15:0]        r_add_b;

    logic [15:0]        r_mem_res [FIFO_DEPTH];
    logic [TAG_W-1:0]   r_mem_tag [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_fire;
    logic               w_push;
    logic               w_pop;
    logic [c_inf_w-1:0] w_inflight;
    logic [c_sum_w-1:0] w_occupancy;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= ADD_LAT; i++) begin
            w_inflight = w_inflight + c_inf_w'(r_vld_pipe[i]);
        end
    end

    // Credits count both FIFO entries and operations still inside the adder,
    // so every result arriving from the adder is guaranteed a free slot.
    assign w_occupancy = c_sum_w'(r_count) + c_sum_w'(w_inflight);
    assign in_ready    = (w_occupancy < c_sum_w'(FIFO_DEPTH));

    assign w_fire    = in_valid & in_ready;
    assign w_push    = r_vld_pipe[ADD_LAT];
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;

    assign add_a = r_add_a;
    assign add_b = r_add_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            for (int i = 0; i <= ADD_LAT; i++) begin
                r_tag_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe <= {r_vld_pipe[ADD_LAT-1:0], w_fire};
            if (w_fire) begin
                r_add_a       <= in_a;
                r_add_b       <= in_b;
                r_tag_pipe[0] <= in_tag;
            end
            for (int i = 1; i <= ADD_LAT; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
        end
    end

    // Storage is not reset; validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_res[r_wr_ptr] <= add_result;
            r_mem_tag[r_wr_ptr] <= r_tag_pipe[ADD_LAT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0
                          : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0
                          : r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head data is masked while empty so the outputs read zero out of reset.
    assign out_result = out_valid ? r_mem_res[r_rd_ptr] : '0;
    assign out_tag    = out_valid ? r_mem_tag[r_rd_ptr] : '0;

    assign busy = (w_inflight != '0) | out_valid;

endmodule

`default_nettype wire

// File: tb/tb_fp16_add_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_fp16_add_stream
// Description : Self-checking bench for fp16_add_stream with a 2-stage adder model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fp16_add_stream;

    localparam int ADD_LAT    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int TAG_W      = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [15:0]      add_result;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    fp16_add_stream #(
        .ADD_LAT    (ADD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
        logic [15:0]      res;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Known fp16 sums; anything else gets an arbitrary but deterministic mix.
    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_3C00: return 16'h4000;
            32'h7C00_FC00: return 16'h7E01;
            32'h0000_BC00: return 16'hBC00;
            32'h3C00_BC00: return 16'h0000;
            32'h4000_3C00: return 16'h4200;
            32'h7BFF_7BFF: return 16'h7C00;
            default:       return a ^ {b[7:0], b[15:8]};
        endcase
    endfunction

    logic [15:0] s1, s2;
    always @(posedge clk) begin
        s1 <= model_add(add_a, add_b);
        s2 <= s1;
    end
    assign add_result = s2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb.push_back('{res: model_add(in_a, in_b), tag: in_tag});
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got result 0x%0h tag %0d, want none", out_result, out_tag);
            end else begin
                mon_e = sb.pop_front();
                check("out_result", 32'(out_result), 32'(mon_e.res));
                check("out_tag", 32'(out_tag), 32'(mon_e.tag));
                n_pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   lat, stall, fires, drops, ov_cnt, ov_first, ov_last, pops0, stale;

        vecs[0] = '{16'h3C00, 16'h3C00, 4'd5,  16'h4000};
        vecs[1] = '{16'h7C00, 16'hFC00, 4'd9,  16'h7E01};
        vecs[2] = '{16'h0000, 16'hBC00, 4'd0,  16'hBC00};
        vecs[3] = '{16'h3C00, 16'hBC00, 4'd15, 16'h0000};
        vecs[4] = '{16'h4000, 16'h3C00, 4'd3,  16'h4200};
        vecs[5] = '{16'h7BFF, 16'h7BFF, 4'd12, 16'h7C00};

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_add_a", 32'(add_a), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_result", 32'(out_result), 0);
        check("post_rst_out_tag", 32'(out_tag), 0);
        check("post_rst_add_b", 32'(add_b), 0);
        @(posedge clk);
        #1;

        // Single operations from the vector table: latency, pass-through, hold
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            in_tag   = vecs[i].tag;
            @(negedge clk);
            check("vec_in_ready", 32'(in_ready), 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_a     = 16'hDEAD;
            in_b     = 16'hBEEF;
            lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                @(negedge clk);
                if (k == 1) check("vec_busy", 32'(busy), 1);
                if (out_valid) begin
                    lat = k;
                    check("vec_result", 32'(out_result), 32'(vecs[i].res));
                    check("vec_tag", 32'(out_tag), 32'(vecs[i].tag));
                end
            end
            check("vec_latency", lat, 4);
            check("vec_add_a_hold", 32'(add_a), 32'(vecs[i].a));
            check("vec_add_b_hold", 32'(add_b), 32'(vecs[i].b));
            for (int k = 0; k < 10 && busy; k++) @(negedge clk);
            check("vec_idle", 32'(busy), 0);
            @(posedge clk);
            #1;
        end

        // 32 back-to-back operations, consumer always ready
        stall = 0; ov_cnt = 0; ov_first = -1; ov_last = -1;
        in_valid = 1'b1;
        for (int j = 0; j < 44; j++) begin
            if (j < 32) begin
                in_a   = 16'h1000 + 16'(j * 273);
                in_b   = 16'(j * 5 + 3);
                in_tag = TAG_W'(j);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j < 32 && !in_ready) stall++;
            if (out_valid) begin
                if (ov_first < 0) ov_first = j;
                ov_last = j;
                ov_cnt++;
            end
            @(posedge clk);
            #1;
        end
        check("b2b_stalls", stall, 0);
        check("b2b_out_count", ov_cnt, 32);
        check("b2b_contiguous", ov_last - ov_first + 1, 32);
        check("b2b_first_out", ov_first, 4);

        // Consumer stalled: exactly FIFO_DEPTH admissions
        out_ready = 1'b0;
        in_valid  = 1'b1;
        fires     = 0;
        in_a = 16'h2000; in_b = 16'h0100; in_tag = 4'd3;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (in_ready) fires++;
            @(posedge clk);
            #1;
            in_a   = 16'h2000 + 16'(fires);
            in_tag = TAG_W'(fires + 3);
        end
        check("stall_fires", fires, 8);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_out_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pops0 = n_pops;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("stall_drained", n_pops - pops0, 8);
        @(negedge clk);
        check("stall_in_ready_back", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Full FIFO, then sustained push+pop with pointer wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        fires     = 0;
        in_b = 16'h0055;
        in_a = 16'h3000; in_tag = 4'd0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (in_ready) fires++;
            @(posedge clk);
            #1;
            in_a   = 16'h3000 + 16'(fires);
            in_tag = TAG_W'(fires);
        end
        check("fill_fires", fires, 8);
        out_ready = 1'b1;
        fires = 0; drops = 0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (j == 0) check("full_in_ready", 32'(in_ready), 0);
            if (!out_valid) drops++;
            if (in_ready) fires++;
            @(posedge clk);
            #1;
            in_a   = 16'h3100 + 16'(fires);
            in_tag = TAG_W'(fires + 8);
        end
        check("wrap_out_drops", drops, 0);
        check("wrap_fires", fires, 23);
        in_valid = 1'b0;
        for (int k = 0; k < 30 && busy; k++) @(negedge clk);
        check("wrap_idle", 32'(busy), 0);
        check("wrap_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset with 3 in flight and 2 in the FIFO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            in_a   = 16'h4400 + 16'(j);
            in_tag = TAG_W'(j + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 1);
        check("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_add_a", 32'(add_a), 0);
        check("arst_add_b", 32'(add_b), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_result", 32'(out_result), 0);
        check("arst_out_tag", 32'(out_tag), 0);
        check("arst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid || busy) stale++;
        end
        check("no_stale_after_rst", stale, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
